fft_frame_ctrl: RTL and testbench

- Frame sequencer for the FFT frontend sample source (the address-counter/data generator).
- Generates the source's clock-gate enable so that exactly N samples per frame are produced, for M frames, with a programmable idle gap between frames.
- Honours downstream back-pressure and reports frame boundaries, progress and completion.
- Sits between the frontend configuration/control interface and the sample source.

---
 rtl/fft_fe_pkg.sv | 16 +
 rtl/fft_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_fe_pkg.sv
// Shared types and default widths for the FFT frontend sample path.
package fft_fe_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRM_WIDTH  = 4;
  localparam int unsigned DEF_GAP_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } fe_state_e;

endpackage

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: gates the sample source so it emits N samples per frame for
// M frames, with a programmable idle gap, honouring downstream ready and abort.
module fft_frame_ctrl
  import fft_fe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned FRM_WIDTH  = DEF_FRM_WIDTH,
  parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH
) (
  input  logic                  clk_cg_i,
  input  logic                  rst_b_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] cfg_len_m1_i,
  input  logic [FRM_WIDTH-1:0]  cfg_nfrm_m1_i,
  input  logic [GAP_WIDTH-1:0]  cfg_gap_i,
  input  logic                  dn_rdy_i,
  output logic                  enb_cg_o,
  output logic [ADDR_WIDTH-1:0] smp_idx_o,
  output logic [FRM_WIDTH-1:0]  frm_idx_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o
);

  fe_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] smp_q, smp_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [FRM_WIDTH-1:0]  frm_q, frm_d;
  logic [FRM_WIDTH-1:0]  nfrm_q, nfrm_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gcnt_q, gcnt_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_smp, last_frm;

  // Ready/abort to enable is the one deliberate combinational path.
  assign enb_cg_o = (state_q == ST_RUN) & dn_rdy_i & ~abort_i;
  assign last_smp = (smp_q == len_q);
  assign last_frm = (frm_q == nfrm_q);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    frm_d   = frm_q;
    len_d   = len_q;
    nfrm_d  = nfrm_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          len_d   = cfg_len_m1_i;
          nfrm_d  = cfg_nfrm_m1_i;
          gap_d   = cfg_gap_i;
          smp_d   = '0;
          frm_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          smp_d   = '0;
          frm_d   = '0;
          state_d = ST_IDLE;
        end else if (dn_rdy_i) begin
          if (last_smp && last_frm) begin
            state_d = ST_DONE;
          end else if (last_smp) begin
            smp_d = '0;
            frm_d = frm_q + FRM_WIDTH'(1);
            if (gap_q != '0) begin
              gcnt_d  = gap_q;
              state_d = ST_GAP;
            end
          end else begin
            smp_d = smp_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          smp_d   = '0;
          frm_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GAP_WIDTH'(1);
          if (gcnt_q == GAP_WIDTH'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (abort_i) begin
          smp_d = '0;
          frm_d = '0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are precomputed from next state so they come straight off flops.
    sof_d  = (state_d == ST_RUN) && (smp_d == '0);
    eof_d  = (state_d == ST_RUN) && (smp_d == len_d);
    busy_d = (state_d == ST_RUN) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_cg_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q <= ST_IDLE;
      smp_q   <= '0;
      frm_q   <= '0;
      len_q   <= '0;
      nfrm_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      frm_q   <= frm_d;
      len_q   <= len_d;
      nfrm_q  <= nfrm_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign smp_idx_o = smp_q;
  assign frm_idx_o = frm_q;
  assign sof_o     = sof_q;
  assign eof_o     = eof_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed scenarios plus randomized
// runs against a flat sample-number reference model.
module tb_fft_frame_ctrl;

  logic       clk_cg_i;
  logic       rst_b_i;
  logic       start_i;
  logic       abort_i;
  logic [7:0] cfg_len_m1_i;
  logic [3:0] cfg_nfrm_m1_i;
  logic [3:0] cfg_gap_i;
  logic       dn_rdy_i;
  logic       enb_cg_o;
  logic [7:0] smp_idx_o;
  logic [3:0] frm_idx_o;
  logic       sof_o;
  logic       eof_o;
  logic       busy_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: transaction is a flat run of L*N samples numbered by m_k.
  bit m_active, m_done;
  int m_len, m_nfrm, m_gap, m_k, m_wait, m_hs, m_hf;

  fft_frame_ctrl dut (
    .clk_cg_i      (clk_cg_i),
    .rst_b_i       (rst_b_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cfg_len_m1_i  (cfg_len_m1_i),
    .cfg_nfrm_m1_i (cfg_nfrm_m1_i),
    .cfg_gap_i     (cfg_gap_i),
    .dn_rdy_i      (dn_rdy_i),
    .enb_cg_o      (enb_cg_o),
    .smp_idx_o     (smp_idx_o),
    .frm_idx_o     (frm_idx_o),
    .sof_o         (sof_o),
    .eof_o         (eof_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial clk_cg_i = 1'b0;
  always #5 clk_cg_i = ~clk_cg_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_len = 1; m_nfrm = 1; m_gap = 0;
    m_k = 0; m_wait = 0; m_hs = 0; m_hf = 0;
  endtask

  task automatic set_cfg(input int len_m1, input int nfrm_m1, input int gap);
    cfg_len_m1_i  = 8'(len_m1);
    cfg_nfrm_m1_i = 4'(nfrm_m1);
    cfg_gap_i     = 4'(gap);
  endtask

  // One clock cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step(input logic st, input logic ab, input logic rdy);
    logic e_enb;
    int   e_smp, e_frm;
    start_i  = st;
    abort_i  = ab;
    dn_rdy_i = rdy;
    #1;
    e_enb = m_active && (m_wait == 0) && rdy && !ab;
    if (m_active) begin
      e_smp = m_k % m_len;
      e_frm = m_k / m_len;
    end else begin
      e_smp = m_hs;
      e_frm = m_hf;
    end
    check("enb", enb_cg_o, e_enb);
    check("busy", busy_o, m_active);
    check("done", done_o, m_done);
    check("smp_idx", smp_idx_o, e_smp);
    check("frm_idx", frm_idx_o, e_frm);
    if (e_enb) begin
      check("sof", sof_o, e_smp == 0);
      check("eof", eof_o, e_smp == m_len - 1);
    end
    @(posedge clk_cg_i);
    if (m_active) begin
      if (ab) begin
        m_active = 0; m_hs = 0; m_hf = 0;
      end else if (e_enb) begin
        if (m_k == m_len * m_nfrm - 1) begin
          m_active = 0; m_done = 1; m_hs = m_len - 1; m_hf = m_nfrm - 1;
        end else begin
          m_k++;
          if (m_k % m_len == 0) m_wait = m_gap;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end
    end else if (m_done) begin
      m_done = 0;
      if (ab) begin m_hs = 0; m_hf = 0; end
    end else if (st && !ab) begin
      m_len  = int'(cfg_len_m1_i) + 1;
      m_nfrm = int'(cfg_nfrm_m1_i) + 1;
      m_gap  = int'(cfg_gap_i);
      m_k = 0; m_wait = 0; m_active = 1;
    end
    @(negedge clk_cg_i);
  endtask

  // Drain the current transaction; rdy_pct is the percentage of ready cycles.
  task automatic drain(input int rdy_pct, input bit scramble_cfg);
    int budget;
    budget = 6000;
    while ((m_active || m_done) && budget > 0) begin
      if (scramble_cfg) set_cfg($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15));
      step(1'b0, 1'b0, $urandom_range(0, 99) < rdy_pct);
      budget--;
    end
    check("drain_timeout", budget > 0, 1);
  endtask

  initial begin
    rst_b_i = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    dn_rdy_i = 1'b1;
    set_cfg(0, 0, 0);
    model_reset();
    @(negedge clk_cg_i);
    // Reset values
    check("rst_enb", enb_cg_o, 0);
    check("rst_sof", sof_o, 0);
    check("rst_eof", eof_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_smp", smp_idx_o, 0);
    check("rst_frm", frm_idx_o, 0);
    rst_b_i = 1'b1;
    step(1'b0, 1'b0, 1'b1);

    // Basic: 2 frames of 4, no gap
    set_cfg(3, 1, 0);
    step(1'b1, 1'b0, 1'b1);
    drain(100, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Gap: 3 frames of 2, gap 3
    set_cfg(1, 2, 3);
    step(1'b1, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Back-pressure on 2nd and 3rd RUN cycles
    set_cfg(3, 0, 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    drain(100, 1'b0);

    // Abort at smp_idx=2 of frame 1, then a full rerun
    set_cfg(3, 1, 0);
    step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    check("abort_pos", smp_idx_o, 2);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Single-sample transaction
    set_cfg(0, 0, 0);
    step(1'b1, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Start while busy is ignored
    set_cfg(2, 1, 2);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    set_cfg(7, 3, 0);
    step(1'b1, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Start and abort together in IDLE
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Full-length frames
    set_cfg(255, 1, 0);
    step(1'b1, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Randomized runs with back-pressure, stray starts, aborts and cfg churn
    for (int r = 0; r < 30; r++) begin
      set_cfg($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4));
      step(1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 200 && (m_active || m_done); c++) begin
        set_cfg($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15));
        step($urandom_range(0, 99) < 5,
             m_done ? 1'b0 : 1'($urandom_range(0, 99) < 2),
             $urandom_range(0, 99) < 75);
      end
      drain(75, 1'b1);
    end

    // Async reset mid-GAP
    set_cfg(1, 1, 5);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check("gap_busy", busy_o, 1);
    #2 rst_b_i = 1'b0;
    #1;
    check("arst_enb", enb_cg_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_smp", smp_idx_o, 0);
    check("arst_frm", frm_idx_o, 0);
    check("arst_sof", sof_o, 0);
    check("arst_eof", eof_o, 0);
    @(negedge clk_cg_i);
    rst_b_i = 1'b1;
    model_reset();
    repeat (4) step(1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
